counter: RTL and testbench

- Registered byte population counter: counts the 1 bits and 0 bits in an input word and presents both counts one clock later.
- Sits in datapath status/statistics logic wherever a per-word bit tally is needed; consumers sample the outputs when `out_valid` is high.
- Combinational adder tree feeds an output register stage.
- Also provides derived flags (all-ones, all-zeros, parity) from the same count.

---
 rtl/counter.sv | 79 +++++++
 tb/tb_counter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Registered population counter: tallies the 1 and 0 bits of an accepted word
// and presents both counts, plus all-ones/all-zeros/parity flags, one cycle later.
module counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] num,
    output logic [CW-1:0]    ones,
    output logic [CW-1:0]    zeroes,
    output logic             out_valid,
    output logic             all_ones,
    output logic             all_zeros,
    output logic             parity
);

    logic [CW-1:0] pop;
    logic [CW-1:0] ones_d, ones_q;
    logic [CW-1:0] zeroes_d, zeroes_q;
    logic          out_valid_d, out_valid_q;
    logic          all_ones_d, all_ones_q;
    logic          all_zeros_d, all_zeros_q;
    logic          parity_d, parity_q;

    // Adder tree: each bit is widened to CW before summing so nothing can overflow.
    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pop = pop + CW'(num[i]);
        end
    end

    // Next state: load on accept, otherwise hold counts/flags and drop out_valid.
    always_comb begin
        ones_d      = ones_q;
        zeroes_d    = zeroes_q;
        all_ones_d  = all_ones_q;
        all_zeros_d = all_zeros_q;
        parity_d    = parity_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            ones_d      = pop;
            zeroes_d    = CW'(WIDTH) - pop;
            all_ones_d  = (pop == CW'(WIDTH));
            all_zeros_d = (pop == '0);
            parity_d    = ^num;
            out_valid_d = 1'b1;
        end
    end

    // Output register stage; reset wins over any word presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q      <= '0;
            zeroes_q    <= '0;
            out_valid_q <= 1'b0;
            all_ones_q  <= 1'b0;
            all_zeros_q <= 1'b0;
            parity_q    <= 1'b0;
        end else begin
            ones_q      <= ones_d;
            zeroes_q    <= zeroes_d;
            out_valid_q <= out_valid_d;
            all_ones_q  <= all_ones_d;
            all_zeros_q <= all_zeros_d;
            parity_q    <= parity_d;
        end
    end

    assign ones      = ones_q;
    assign zeroes    = zeroes_q;
    assign out_valid = out_valid_q;
    assign all_ones  = all_ones_q;
    assign all_zeros = all_zeros_q;
    assign parity    = parity_q;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: expected outputs are pushed to a scoreboard queue
// as each step is driven and popped/compared one clock later.
module tb_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] num;
    logic [3:0] ones, zeroes;
    logic       out_valid, all_ones, all_zeros, parity;

    logic       in_valid5;
    logic [4:0] num5;
    logic [2:0] ones5, zeroes5;
    logic       out_valid5, all_ones5, all_zeros5, parity5;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic       v;
        logic [3:0] o;
        logic [3:0] z;
        logic       ao;
        logic       az;
        logic       p;
    } exp_t;

    exp_t sb[$];
    exp_t mdl;

    always #5 clk = ~clk;

    counter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .num       (num),
        .ones      (ones),
        .zeroes    (zeroes),
        .out_valid (out_valid),
        .all_ones  (all_ones),
        .all_zeros (all_zeros),
        .parity    (parity)
    );

    counter #(.WIDTH(5)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid5),
        .num       (num5),
        .ones      (ones5),
        .zeroes    (zeroes5),
        .out_valid (out_valid5),
        .all_ones  (all_ones5),
        .all_zeros (all_zeros5),
        .parity    (parity5)
    );

    function automatic int popcnt(input logic [7:0] n);
        int c = 0;
        for (int i = 0; i < 8; i++) if (n[i]) c++;
        return c;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the model's prediction, then compare after the edge.
    task automatic step(input logic r, input logic v, input logic [7:0] n, input string tag);
        exp_t e;
        int pc;
        rst      = r;
        in_valid = v;
        num      = n;
        if (r) begin
            mdl = '0;
        end else if (v) begin
            pc     = popcnt(n);
            mdl.v  = 1'b1;
            mdl.o  = 4'(pc);
            mdl.z  = 4'(8 - pc);
            mdl.ao = (pc == 8);
            mdl.az = (pc == 0);
            mdl.p  = pc[0];
        end else begin
            mdl.v = 1'b0;
        end
        sb.push_back(mdl);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".out_valid"}, int'(out_valid), int'(e.v));
        check({tag, ".ones"},      int'(ones),      int'(e.o));
        check({tag, ".zeroes"},    int'(zeroes),    int'(e.z));
        check({tag, ".all_ones"},  int'(all_ones),  int'(e.ao));
        check({tag, ".all_zeros"}, int'(all_zeros), int'(e.az));
        check({tag, ".parity"},    int'(parity),    int'(e.p));
        if (out_valid === 1'b1) check({tag, ".sum"}, int'(ones) + int'(zeroes), 8);
    endtask

    initial begin
        logic [7:0] sweep [6];
        sweep[0] = 8'h00; sweep[1] = 8'h11; sweep[2] = 8'h33;
        sweep[3] = 8'h77; sweep[4] = 8'hEE; sweep[5] = 8'hFF;
        mdl       = '0;
        in_valid5 = 1'b0;
        num5      = '0;

        // Reset with a live word present: the word must be discarded.
        step(1'b1, 1'b1, 8'hFF, "reset0");
        step(1'b1, 1'b1, 8'hFF, "reset1");

        // Nibble-replicated sweep, back-to-back.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i * 8'h11), "nibble");
        foreach (sweep[i]) step(1'b0, 1'b1, sweep[i], "sweep");

        // Parity then hold with garbage on num.
        step(1'b0, 1'b1, 8'h01, "parity");
        step(1'b0, 1'b0, 8'hFF, "hold0");
        step(1'b0, 1'b0, 8'hFF, "hold1");
        step(1'b0, 1'b0, 8'bx,  "holdx");

        // Mid-stream reset drops 0xAA.
        step(1'b0, 1'b1, 8'h55, "mid55");
        step(1'b1, 1'b1, 8'hAA, "midrst");
        step(1'b0, 1'b0, 8'h00, "postrst");
        step(1'b0, 1'b1, 8'hC3, "afterrst");

        // Exhaustive, back-to-back.
        for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 8'(i), "exh");
        step(1'b0, 1'b0, 8'h00, "drain");

        // Narrow instance.
        in_valid5 = 1'b1;
        num5      = 5'h1F;
        @(posedge clk);
        #1;
        in_valid5 = 1'b0;
        check("w5.out_valid", int'(out_valid5), 1);
        check("w5.ones",      int'(ones5),      5);
        check("w5.zeroes",    int'(zeroes5),    0);
        check("w5.all_ones",  int'(all_ones5),  1);
        check("w5.all_zeros", int'(all_zeros5), 0);
        check("w5.parity",    int'(parity5),    1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
